spi_mux_ctrl: RTL and testbench

Register-mapped SPI command controller for the LED output mux. It recovers SPI mode-0 frames in the 50 MHz clk domain and decodes a command byte. Write commands configure the channel enable mask and the channel select. Read commands return register contents on MISO. A stream command forwards payload bytes to the output datapath with a one-cycle valid strobe. It replaces free-running shift-to-output behaviour with framed, byte-aligned transfers.

---
 rtl/spi_mux_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_spi_mux_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mux_ctrl.sv
// rtl/spi_mux_ctrl.sv - framed SPI mode-0 command controller for the LED output mux
module spi_mux_ctrl #(
   parameter int SYNC_STAGES = 2,
   parameter int NUM_CH      = 4,
   localparam int CSW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              spi_nCS,
   input  logic              spi_sck,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              spi_miso_oe,
   output logic [NUM_CH-1:0] out_en,
   output logic [CSW-1:0]    ch_sel,
   output logic [7:0]        data,
   output logic              data_valid,
   output logic              frame_err,
   output logic              busy
);

   typedef enum logic [2:0] {WAIT_CS, IDLE, CMD, WR, STREAM, RD, DRAIN} state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] ncs_p;
   logic [SYNC_STAGES-1:0] mosi_p;
   logic [SYNC_STAGES:0]   sck_p;     // top bit is the previous synced SCK for edge detection
   logic                   ncs_q;
   logic                   mosi_q;
   logic                   rise_q;
   logic                   fall_q;
   logic [2:0]             cnt;
   logic [6:0]             shin;      // first seven bits of the byte being received
   logic [6:0]             shout;     // remaining read bits after the one on MISO
   logic [1:0]             addr;
   logic [7:0]             rx_byte;
   logic [7:0]             rd_val;
   logic                   byte_done;

   assign rx_byte   = {shin, mosi_q};
   assign byte_done = rise_q && (cnt == 3'd7);
   assign busy      = (state != IDLE) && (state != WAIT_CS);

   // Synchronise the async SPI pins and register the SCK edge pulses alongside the data they qualify
   always_ff @(posedge clk) begin
      if (!reset) begin
         ncs_p  <= '0;
         mosi_p <= '0;
         sck_p  <= '0;
         ncs_q  <= 1'b0;
         mosi_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         ncs_p  <= {ncs_p[SYNC_STAGES-2:0], spi_nCS};
         mosi_p <= {mosi_p[SYNC_STAGES-2:0], spi_mosi};
         sck_p  <= {sck_p[SYNC_STAGES-1:0], spi_sck};
         ncs_q  <= ncs_p[SYNC_STAGES-1];
         mosi_q <= mosi_p[SYNC_STAGES-1];
         rise_q <= sck_p[SYNC_STAGES-1] & ~sck_p[SYNC_STAGES];
         fall_q <= ~sck_p[SYNC_STAGES-1] & sck_p[SYNC_STAGES];
      end
   end

   // Register readback value for the address carried by the command byte just completed
   always_comb begin
      rd_val = '0;
      case (rx_byte[3:0])
         4'h0:    rd_val[NUM_CH-1:0] = out_en;
         4'h1:    rd_val[CSW-1:0]    = ch_sel;
         4'h2:    rd_val[1:0]        = {busy, frame_err};
         default: rd_val             = '0;
      endcase
   end

   // Frame state machine: command decode, register writes, stream output and MISO shifting
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= WAIT_CS;
         cnt         <= '0;
         shin        <= '0;
         shout       <= '0;
         addr        <= '0;
         out_en      <= '0;
         ch_sel      <= '0;
         data        <= '0;
         data_valid  <= 1'b0;
         spi_miso    <= 1'b0;
         spi_miso_oe <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         case (state)
            WAIT_CS: if (ncs_q) state <= IDLE;
            IDLE: begin
               if (!ncs_q) begin
                  state <= CMD;
                  cnt   <= '0;
               end
            end
            default: begin
               if (ncs_q) begin
                  // CS released mid-frame: a partial byte is a framing error and is discarded
                  state       <= IDLE;
                  spi_miso_oe <= 1'b0;
                  spi_miso    <= 1'b0;
                  cnt         <= '0;
                  if (cnt != 3'd0) frame_err <= 1'b1;
               end else begin
                  case (state)
                     CMD: begin
                        if (rise_q) begin
                           shin <= rx_byte[6:0];
                           cnt  <= cnt + 3'd1;
                           if (byte_done) begin
                              addr <= rx_byte[1:0];
                              if (rx_byte[3:0] < 4'h3) begin
                                 if (rx_byte[7]) begin
                                    state <= WR;
                                 end else begin
                                    state       <= RD;
                                    shout       <= rd_val[6:0];
                                    spi_miso    <= rd_val[7];
                                    spi_miso_oe <= 1'b1;
                                 end
                              end else if (rx_byte[7] && (rx_byte[3:0] == 4'h3)) begin
                                 state <= STREAM;
                              end else begin
                                 state <= DRAIN;
                              end
                           end
                        end
                     end
                     WR: begin
                        if (rise_q) begin
                           shin <= rx_byte[6:0];
                           cnt  <= cnt + 3'd1;
                           if (byte_done) begin
                              case (addr)
                                 2'd0:    out_en <= rx_byte[NUM_CH-1:0];
                                 2'd1:    ch_sel <= rx_byte[CSW-1:0];
                                 2'd2:    if (rx_byte[0]) frame_err <= 1'b0;
                                 default: ;
                              endcase
                              state <= DRAIN;
                           end
                        end
                     end
                     STREAM: begin
                        if (rise_q) begin
                           shin <= rx_byte[6:0];
                           cnt  <= cnt + 3'd1;
                           if (byte_done) begin
                              data       <= rx_byte;
                              data_valid <= 1'b1;
                           end
                        end
                     end
                     RD: begin
                        if (rise_q) begin
                           cnt <= cnt + 3'd1;
                           if (cnt == 3'd7) begin
                              state       <= DRAIN;
                              spi_miso_oe <= 1'b0;
                              spi_miso    <= 1'b0;
                           end
                        end else if (fall_q && (cnt != 3'd0)) begin
                           // the fall that ends the command byte must not shift
                           spi_miso <= shout[6];
                           shout    <= {shout[5:0], 1'b0};
                        end
                     end
                     DRAIN:   ;
                     default: state <= WAIT_CS;
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_mux_ctrl.sv
// tb/tb_spi_mux_ctrl.sv - self-checking bench for spi_mux_ctrl
module tb_spi_mux_ctrl;

   localparam int S    = 2;
   localparam int HALF = 6;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       spi_nCS = 1'b0;
   logic       spi_sck = 1'b0;
   logic       spi_mosi = 1'b0;
   logic       spi_miso;
   logic       spi_miso_oe;
   logic [3:0] out_en;
   logic [1:0] ch_sel;
   logic [7:0] data;
   logic       data_valid;
   logic       frame_err;
   logic       busy;

   spi_mux_ctrl #(.SYNC_STAGES(S), .NUM_CH(4)) dut (
      .clk(clk), .reset(reset), .spi_nCS(spi_nCS), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .out_en(out_en), .ch_sel(ch_sel),
      .data(data), .data_valid(data_valid), .frame_err(frame_err), .busy(busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   typedef struct { int c; logic [7:0] d; } ev_t;
   ev_t got_q[$];
   ev_t exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (data_valid) got_q.push_back('{c: cyc, d: data});

   logic [3:0] m_out_en;
   logic [1:0] m_ch_sel;
   logic       m_err;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic xfer(input logic [7:0] b, input int nb, output logic [7:0] mi,
                       output logic [7:0] oe, output int rc);
      mi = '0; oe = '0; rc = 0;
      for (int i = 0; i < nb; i++) begin
         spi_mosi = b[7-i];
         tick(HALF);
         spi_sck = 1'b1;
         mi[7-i] = spi_miso;
         oe[7-i] = spi_miso_oe;
         rc = cyc;
         tick(HALF);
         spi_sck = 1'b0;
      end
   endtask

   task automatic check_stream();
      ev_t g, e;
      chk("stream_cnt", 32'(got_q.size()), 32'(exp_q.size()));
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         chk("stream_data", 32'(g.d), 32'(e.d));
         chk("stream_latency", 32'(g.c), 32'(e.c));
      end
      got_q.delete();
      exp_q.delete();
   endtask

   // One framed transfer of nb whole bytes plus tail extra bits, checked against the frame-level model
   task automatic do_frame(input logic [31:0] fr, input int nb, input int tail, output logic [7:0] rd_got);
      logic [7:0] bb[4];
      logic [7:0] mi, oe, exp_rd;
      int         rc;
      logic       w;
      logic [3:0] a;
      bit         is_wr, is_st, is_rd;
      rd_got = '0;
      for (int i = 0; i < 4; i++) bb[i] = fr[8*(3-i) +: 8];
      w     = bb[0][7];
      a     = bb[0][3:0];
      is_wr = w && (a < 4'd3);
      is_st = w && (a == 4'd3);
      is_rd = !w && (a < 4'd3);
      case (a)
         4'd0:    exp_rd = {4'b0, m_out_en};
         4'd1:    exp_rd = {6'b0, m_ch_sel};
         default: exp_rd = {6'b0, 1'b1, m_err};
      endcase
      spi_nCS = 1'b0;
      tick(HALF);
      for (int i = 0; i < nb; i++) begin
         xfer(bb[i], 8, mi, oe, rc);
         if (is_rd && i == 1) begin
            chk("rd_oe", 32'(oe), 32'hFF);
            chk("rd_data", 32'(mi), 32'(exp_rd));
            rd_got = mi;
         end else begin
            chk("quiet_oe", 32'(oe), 32'h0);
            chk("quiet_miso", 32'(mi), 32'h0);
         end
         if (is_st && i >= 1) exp_q.push_back('{c: rc + S + 2, d: bb[i]});
         if (is_wr && i == 1) begin
            case (a)
               4'd0:    m_out_en = bb[1][3:0];
               4'd1:    m_ch_sel = bb[1][1:0];
               default: if (bb[1][0]) m_err = 1'b0;
            endcase
            chk("wr_out_en_early", 32'(out_en), 32'(m_out_en));
            chk("wr_ch_sel_early", 32'(ch_sel), 32'(m_ch_sel));
         end
      end
      if (tail > 0) xfer(bb[nb], tail, mi, oe, rc);
      tick(HALF);
      spi_nCS = 1'b1;
      tick(2 * HALF);
      if (tail > 0 && (nb == 0 || is_st || (nb == 1 && (is_wr || is_rd)))) m_err = 1'b1;
      chk("out_en", 32'(out_en), 32'(m_out_en));
      chk("ch_sel", 32'(ch_sel), 32'(m_ch_sel));
      chk("frame_err", 32'(frame_err), 32'(m_err));
      chk("idle_bus", 32'({busy, spi_miso_oe, spi_miso}), 32'h0);
      check_stream();
   endtask

   typedef struct {
      logic [31:0] fr;
      int          nb;
      int          tail;
      logic [3:0]  e_en;
      logic [1:0]  e_sel;
      logic        e_err;
      logic [8:0]  e_rd;   // bit8 set: a read byte is expected
   } vec_t;

   vec_t vecs[12];

   initial begin
      logic [7:0]  mi, oe, rd;
      int          rc, nb, tail;
      logic [7:0]  c;

      vecs[0]  = '{32'h800FFF00, 3, 0, 4'hF, 2'd0, 1'b0, 9'h000};
      vecs[1]  = '{32'h81020000, 2, 0, 4'hF, 2'd2, 1'b0, 9'h000};
      vecs[2]  = '{32'h01000000, 2, 0, 4'hF, 2'd2, 1'b0, 9'h102};
      vecs[3]  = '{32'h83A53C00, 3, 0, 4'hF, 2'd2, 1'b0, 9'h000};
      vecs[4]  = '{32'h83000000, 1, 5, 4'hF, 2'd2, 1'b1, 9'h000};
      vecs[5]  = '{32'h02000000, 2, 0, 4'hF, 2'd2, 1'b1, 9'h103};
      vecs[6]  = '{32'h00000000, 2, 0, 4'hF, 2'd2, 1'b1, 9'h10F};
      vecs[7]  = '{32'h82010000, 2, 0, 4'hF, 2'd2, 1'b0, 9'h000};
      vecs[8]  = '{32'h8F550000, 2, 0, 4'hF, 2'd2, 1'b0, 9'h000};
      vecs[9]  = '{32'h80050000, 2, 0, 4'h5, 2'd2, 1'b0, 9'h000};
      vecs[10] = '{32'h81FF0000, 1, 3, 4'h5, 2'd2, 1'b1, 9'h000};
      vecs[11] = '{32'h82010000, 2, 0, 4'h5, 2'd2, 1'b0, 9'h000};

      m_out_en = '0; m_ch_sel = '0; m_err = 1'b0;

      // reset with nCS held low, then SCK activity while still waiting for CS high
      reset = 1'b0; spi_nCS = 1'b0;
      tick(5);
      chk("reset_outputs", 32'({out_en, ch_sel, data, data_valid, spi_miso, spi_miso_oe, frame_err, busy}), 32'h0);
      reset = 1'b1;
      tick(2);
      xfer(8'h80, 8, mi, oe, rc);
      xfer(8'h0F, 8, mi, oe, rc);
      tick(HALF);
      chk("wait_cs_no_write", 32'({out_en, busy, spi_miso_oe}), 32'h0);
      spi_nCS = 1'b1;
      tick(2 * HALF);
      check_stream();

      // directed table
      for (int v = 0; v < 12; v++) begin
         do_frame(vecs[v].fr, vecs[v].nb, vecs[v].tail, rd);
         chk("vec_out_en", 32'(out_en), 32'(vecs[v].e_en));
         chk("vec_ch_sel", 32'(ch_sel), 32'(vecs[v].e_sel));
         chk("vec_frame_err", 32'(frame_err), 32'(vecs[v].e_err));
         if (vecs[v].e_rd[8]) chk("vec_rd", 32'(rd), 32'(vecs[v].e_rd[7:0]));
      end

      // reset asserted mid-stream
      spi_nCS = 1'b0;
      tick(HALF);
      xfer(8'h83, 8, mi, oe, rc);
      xfer(8'hA5, 8, mi, oe, rc);
      exp_q.push_back('{c: rc + S + 2, d: 8'hA5});
      xfer(8'hC3, 3, mi, oe, rc);
      reset = 1'b0;
      tick(1);
      chk("midreset_outputs", 32'({out_en, ch_sel, data, data_valid, spi_miso, spi_miso_oe, frame_err, busy}), 32'h0);
      reset = 1'b1;
      m_out_en = '0; m_ch_sel = '0; m_err = 1'b0;
      tick(2);
      xfer(8'h80, 8, mi, oe, rc);
      xfer(8'h0F, 8, mi, oe, rc);
      tick(HALF);
      chk("midreset_no_resume", 32'({out_en, busy}), 32'h0);
      spi_nCS = 1'b1;
      tick(2 * HALF);
      check_stream();
      do_frame(32'h81010000, 2, 0, rd);

      // randomized frames against the model
      for (int k = 0; k < 30; k++) begin
         c = 8'($urandom);
         if ($urandom_range(0, 3) != 0) c[3:0] = 4'($urandom_range(0, 3));
         nb   = int'($urandom_range(1, 3));
         tail = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
         if ($urandom_range(0, 9) == 0) begin
            nb = 0;
            if (tail == 0) tail = 4;
         end
         do_frame({c, 8'($urandom), 8'($urandom), 8'($urandom)}, nb, tail, rd);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
